// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the RV32M sequential multiply/divide
//               unit: funct3 opcodes, FSM state encoding, divide special
//               results and operand-signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // M-extension opcodes (inst[14:12])
    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_FIX     = 3'd2,
        S_SPECIAL = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // RV32 divide corner-case results
    localparam logic [31:0] c_div_zero_q = 32'hFFFF_FFFF;
    localparam logic [31:0] c_div_ovf_q  = 32'h8000_0000;
    localparam logic [31:0] c_div_ovf_r  = 32'h0000_0000;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        return (f3 == c_f3_mulh) || (f3 == c_f3_mulhsu) ||
               (f3 == c_f3_div)  || (f3 == c_f3_rem);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        return (f3 == c_f3_mulh) || (f3 == c_f3_div) || (f3 == c_f3_rem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/response bundle between the EX stage and the
//               sequential multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Pipeline side: issues operations, observes completion
    modport master (
        output start, flush, funct3, rs1, rs2,
        input  ready, busy, done, result
    );

    // Unit side
    modport slave (
        input  start, flush, funct3, rs1, rs2,
        output ready, busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : Combinational single-iteration cell shared by multiply and
//               divide. Multiply: shift-add, multiplier LSB first, product
//               accumulates from the top and shifts right. Divide: restoring,
//               remainder in the upper half, quotient bits shift in at bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  wire logic [2*XLEN-1:0] acc,
    input  wire logic [XLEN-1:0]   operand,   // multiplicand or divisor
    input  wire logic              in_bit,    // multiplier LSB or dividend MSB
    input  wire logic              is_div,
    output logic      [2*XLEN-1:0] next_acc,  // quotient bit position left 0
    output logic                   q_bit
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN+1:0] w_diff;
    logic            w_unused;

    // One iteration of either shift-add multiply or restoring divide
    always_comb begin
        w_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (in_bit ? {1'b0, operand} : {(XLEN+1){1'b0}});
        w_rem_sh = {acc[2*XLEN-1:XLEN], in_bit};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, operand};
        q_bit    = 1'b0;
        next_acc = {w_sum, acc[XLEN-1:1]};
        if (is_div) begin
            // Non-negative trial difference: keep it and set the quotient bit
            q_bit    = ~w_diff[XLEN+1];
            next_acc = {(q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                        acc[XLEN-2:0], 1'b0};
        end
    end

    // The remainder always fits XLEN bits, so these top bits are never needed
    assign w_unused = ^{w_diff[XLEN], w_rem_sh[XLEN]};

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32M multiply/divide unit with its own sequencer.
//               One shared shift/add-subtract cell, one bit per cycle.
//               Optional macro MULDIV_FAST_MUL_EN: multiplies complete via a
//               single-cycle signed multiplier (IDLE -> FIX -> DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  wire logic clk,
    input  wire logic rst,
    muldiv_if.slave   bus
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opa;     // |rs1|: multiplicand / dividend
    logic [XLEN-1:0]     r_opb;     // |rs2|: multiplier / divisor
    logic [XLEN-1:0]     r_result;
    logic [2:0]          r_f3;
    logic                r_sa;
    logic                r_sb;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic [XLEN-1:0]     w_special_res;
    logic [2*XLEN-1:0]   w_step_acc;
    logic                w_q_bit;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    // Accept-time decode: sign flags, magnitudes and divide corner cases
    always_comb begin
        w_sa       = f3_rs1_signed(bus.funct3) & bus.rs1[XLEN-1];
        w_sb       = f3_rs2_signed(bus.funct3) & bus.rs2[XLEN-1];
        w_mag_a    = w_sa ? -bus.rs1 : bus.rs1;
        w_mag_b    = w_sb ? -bus.rs2 : bus.rs2;
        w_div_zero = bus.funct3[2] && (bus.rs2 == '0);
        w_div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                     (bus.rs1 == c_div_ovf_q) && (bus.rs2 == '1);
        if (w_div_zero)
            w_special_res = bus.funct3[1] ? bus.rs1 : c_div_zero_q;
        else
            w_special_res = bus.funct3[1] ? c_div_ovf_r : c_div_ovf_q;
    end

`ifdef MULDIV_FAST_MUL_EN
    // Operands sign- or zero-extended as the op requires; low 2*XLEN bits
    // of the signed product are the exact result for every multiply flavour
    logic signed [2*XLEN-1:0] w_fast_a;
    logic signed [2*XLEN-1:0] w_fast_b;
    logic signed [2*XLEN-1:0] w_fast_prod;
    assign w_fast_a    = {{XLEN{w_sa}}, bus.rs1};
    assign w_fast_b    = {{XLEN{w_sb}}, bus.rs2};
    assign w_fast_prod = w_fast_a * w_fast_b;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (r_acc),
        .operand  (r_f3[2] ? r_opb : r_opa),
        .in_bit   (r_f3[2] ? r_opa[XLEN-1] : r_opb[0]),
        .is_div   (r_f3[2]),
        .next_acc (w_step_acc),
        .q_bit    (w_q_bit)
    );

    // Sign correction and output selection applied in FIX
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        case (r_f3)
            c_f3_mul:             w_fix_res = w_prod[XLEN-1:0];
            c_f3_div, c_f3_divu:  w_fix_res = w_quo;
            c_f3_rem, c_f3_remu:  w_fix_res = w_rem;
            default:              w_fix_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    // Sequencer with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_f3     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_state != S_IDLE && bus.flush) begin
            // Abort: no done pulse, result untouched
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_f3    <= bus.funct3;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_opa   <= w_mag_a;
                        r_opb   <= w_mag_b;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_div_zero || w_div_ovf) begin
                            // Corner result parked in the accumulator low word
                            r_acc   <= {{XLEN{1'b0}}, w_special_res};
                            r_state <= S_SPECIAL;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!bus.funct3[2]) begin
                            // Product already signed: no correction in FIX
                            r_acc   <= w_fast_prod;
                            r_sa    <= 1'b0;
                            r_sb    <= 1'b0;
                            r_state <= S_FIX;
                        end
`endif
                        else begin
                            r_acc   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_q_bit};
                    if (r_f3[2])
                        r_opa <= {r_opa[XLEN-2:0], 1'b0};
                    else
                        r_opb <= {1'b0, r_opb[XLEN-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_SPECIAL: begin
                    r_result <= r_acc[XLEN-1:0];
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits beside the main ALU in EX. The decoder routes funct7=0000001 R-type ops here and not to the ALU.
- Asserts busy so the hazard logic stalls IF/ID/EX until the result is ready.
- Uses one shared shift/add-subtract datapath for all eight M-extension ops, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- flush  in  1  pipeline flush; aborts any operation in progress
- funct3  in  3  M-ext op (inst[14:12]): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A (dividend / multiplicand)
- rs2  in  XLEN  operand B (divisor / multiplier)
- ready  out  1  idle, can accept start
- busy  out  1  operation in flight; stall request to hazard unit
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  result register; holds until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, busy=0, done=0, result=0, counter=0, internal registers=0.
- States and transitions:
  - IDLE -> CALC on start&&!flush.
  - IDLE -> SPECIAL when the op is a divide with rs2==0, or signed DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF.
  - CALC -> FIX when counter reaches XLEN-1.
  - FIX -> DONE.
  - SPECIAL -> DONE.
  - DONE -> IDLE unconditionally.
- Accept (IDLE, start=1):
  - Latch funct3 and the sign flags.
  - Latch operand magnitudes: absolute value for signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both). MUL uses raw operands; low word is sign-agnostic.
  - Clear the 2*XLEN accumulator; counter=0.
- CALC, one iteration per cycle, counter++:
  - Multiply: shift-add, LSB of multiplier first; 2*XLEN-bit product.
  - Divide: restoring. Shift remainder left, subtract divisor, keep if non-negative, set quotient bit.
- FIX:
  - Apply sign correction: negate product if signs differ; quotient sign = sA^sB; remainder sign = sA.
  - Select output: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
  - Write result.
- SPECIAL, divide by zero: quotient=all ones (0xFFFFFFFF); remainder=rs1.
- SPECIAL, signed overflow: quotient=0x80000000; remainder=0.
- Latency:
  - Normal op: start accepted in cycle 0; done=1 in cycle XLEN+2 (34).
  - Special op: done=1 in cycle 2.
- Handshake:
  - ready=1 only in IDLE.
  - busy=1 in CALC, FIX, SPECIAL. busy=0 in DONE, so the stalled instruction advances in the done cycle and captures result.
  - start while busy is ignored.
  - start is not accepted in DONE; the earliest back-to-back accept is the cycle after done.
- Flush: in any state other than IDLE, flush=1 returns to IDLE next edge. No done pulse; result keeps its old value.
- Simultaneous events:
  - flush and start in IDLE: start ignored.
  - rst mid-operation: immediate return to the reset values above.
- rs1/rs2/funct3 are don't-care after accept; the block never re-reads them.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - Multiplies (funct3[2]=0) compute in one cycle with a combinational 33x33 signed multiplier.
  - Path is IDLE -> FIX -> DONE; done in cycle 2.
  - Divides unchanged.
- Undefined: all multiplies iterate as above, 34-cycle latency.

Decomposition:
- Package muldiv_pkg holds:
  - F3 opcode constants for the eight M ops.
  - FSM state encoding (IDLE, CALC, FIX, SPECIAL, DONE).
  - The RV32 divide special-result constants: 0xFFFFFFFF for divide-by-zero, 0x80000000 for overflow.
- One natural sub-module: muldiv_step, the combinational single-iteration cell. It takes accumulator, operand, and mode, and returns the next accumulator and quotient bit. The FSM/counter stays in muldiv_seq.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> result=0xFFFFFFEB (-21), done in cycle 34 (2 with MULDIV_FAST_MUL_EN); busy=1 in cycles 1-33.
- MULH/MULHU/MULHSU with rs1=0x80000000, rs2=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHU -> 0x7FFFFFFF
  - MULHSU -> 0x80000000
- DIV rs1=-7, rs2=2 -> quotient 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0. All special cases: done in cycle 2, never enter CALC.
- Abort cases:
  - flush at iteration 10 of DIVU -> ready=1 next cycle, no done, result unchanged.
  - rst asserted mid-CALC -> all outputs at reset values immediately.
- Back-to-back: second start held high from done cycle -> accepted in the cycle after done. start pulses during busy -> ignored; exactly one done per accepted op.
